// File: rtl/game_state_controller.sv
// Game sequencer: button debounce, collide edge detection, lives/score
// bookkeeping and the MENU/RUN/PAUSE/OVER/WIN state machine.

module gsc_debounce #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CMAX) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

module game_state_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HIT_COOLDOWN    = 200000000,
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned WIN_SCORE       = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [3:0] enemy_collide,
  input  logic       food_collide,
  output logic       gamemenu,
  output logic       gamerun,
  output logic       gamepause,
  output logic       gameover,
  output logic       gamewin,
  output logic [7:0] score,
  output logic [2:0] lives
);

  localparam int CDW = $clog2(HIT_COOLDOWN + 1);
  localparam logic [CDW-1:0] CD_LOAD = CDW'(HIT_COOLDOWN);
  localparam logic [2:0]     L_INIT  = 3'(LIVES_INIT);
  localparam logic [7:0]     W_SCORE = 8'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_MENU,
    S_RUN,
    S_PAUSE,
    S_OVER,
    S_WIN
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           start_p;
  logic           pause_p;
  logic [3:0]     enemy_q;
  logic           food_q;
  logic [CDW-1:0] cool_q;
  logic [CDW-1:0] cool_d;
  logic [7:0]     score_q;
  logic [7:0]     score_d;
  logic [2:0]     lives_q;
  logic [2:0]     lives_d;
  logic           hit;
  logic           eat;
  logic           gamemenu_q;
  logic           gamerun_q;
  logic           gamepause_q;
  logic           gameover_q;
  logic           gamewin_q;

  gsc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_start),
    .press_o (start_p)
  );

  gsc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_pause),
    .press_o (pause_p)
  );

  // History tracks levels in every state, so a level already high on
  // re-entering RUN never looks like a fresh edge.
  always_comb begin
    hit = (state_q == S_RUN) && (cool_q == '0)
          && (|(enemy_collide & ~enemy_q));
    eat = (state_q == S_RUN) && food_collide && !food_q;
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    cool_d  = cool_q;
    unique case (state_q)
      S_MENU: begin
        if (start_p) begin
          state_d = S_RUN;
          lives_d = L_INIT;
          score_d = '0;
          cool_d  = '0;
        end
      end
      S_RUN: begin
        if (hit) begin
          lives_d = (lives_q == '0) ? '0 : lives_q - 3'd1;
          cool_d  = CD_LOAD;
        end else if (cool_q != '0) begin
          cool_d = cool_q - CDW'(1);
        end
        if (eat && score_q != 8'hff) begin
          score_d = score_q + 8'd1;
        end
        if (lives_d == '0) begin
          state_d = S_OVER;
        end else if (score_d >= W_SCORE) begin
          state_d = S_WIN;
        end else if (pause_p) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start_p) begin
          state_d = S_MENU;
        end else if (pause_p) begin
          state_d = S_RUN;
        end
      end
      S_OVER, S_WIN: begin
        if (start_p) begin
          state_d = S_MENU;
        end
      end
      default: state_d = S_MENU;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_MENU;
      enemy_q     <= '0;
      food_q      <= 1'b0;
      cool_q      <= '0;
      score_q     <= '0;
      lives_q     <= L_INIT;
      gamemenu_q  <= 1'b1;
      gamerun_q   <= 1'b0;
      gamepause_q <= 1'b0;
      gameover_q  <= 1'b0;
      gamewin_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      enemy_q     <= enemy_collide;
      food_q      <= food_collide;
      cool_q      <= cool_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      gamemenu_q  <= (state_d == S_MENU);
      gamerun_q   <= (state_d == S_RUN);
      gamepause_q <= (state_d == S_PAUSE);
      gameover_q  <= (state_d == S_OVER);
      gamewin_q   <= (state_d == S_WIN);
    end
  end

  assign gamemenu  = gamemenu_q;
  assign gamerun   = gamerun_q;
  assign gamepause = gamepause_q;
  assign gameover  = gameover_q;
  assign gamewin   = gamewin_q;
  assign score     = score_q;
  assign lives     = lives_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller: directed scenarios plus a randomized
// run checked against a cycle-level model of the game rules.

module tb_game_state_controller;

  localparam int DB = 4;
  localparam int HC = 8;
  localparam int LI = 3;
  localparam int WS = 5;
  localparam int NC = 3000;

  localparam logic [4:0] F_MENU  = 5'b10000;
  localparam logic [4:0] F_RUN   = 5'b01000;
  localparam logic [4:0] F_PAUSE = 5'b00100;
  localparam logic [4:0] F_OVER  = 5'b00010;
  localparam logic [4:0] F_WIN   = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic [3:0] enemy_collide = 4'd0;
  logic       food_collide = 1'b0;
  logic       gamemenu;
  logic       gamerun;
  logic       gamepause;
  logic       gameover;
  logic       gamewin;
  logic [7:0] score;
  logic [2:0] lives;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_state_controller #(
    .DEBOUNCE_CYCLES (DB),
    .HIT_COOLDOWN    (HC),
    .LIVES_INIT      (LI),
    .WIN_SCORE       (WS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_start     (btn_start),
    .btn_pause     (btn_pause),
    .enemy_collide (enemy_collide),
    .food_collide  (food_collide),
    .gamemenu      (gamemenu),
    .gamerun       (gamerun),
    .gamepause     (gamepause),
    .gameover      (gameover),
    .gamewin       (gamewin),
    .score         (score),
    .lives         (lives)
  );

  function automatic logic [4:0] flags();
    return {gamemenu, gamerun, gamepause, gameover, gamewin};
  endfunction

  task automatic press(input bit is_start);
    if (is_start) btn_start = 1'b1;
    else btn_pause = 1'b1;
    repeat (10) @(negedge clk);
    btn_start = 1'b0;
    btn_pause = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (flags() !== F_MENU) begin
      errors++;
      $display("FAIL reset_flags got %b want %b", flags(), F_MENU);
    end
    checks++;
    if (score !== 8'd0) begin
      errors++;
      $display("FAIL reset_score got %0d want 0", score);
    end
    checks++;
    if (lives !== 3'(LI)) begin
      errors++;
      $display("FAIL reset_lives got %0d want %0d", lives, LI);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_start();
    logic [4:0] prev;
    int first;
    int changes;
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (flags() !== F_MENU) begin
      errors++;
      $display("FAIL start_glitch got %b want %b", flags(), F_MENU);
    end
    first = -1;
    changes = 0;
    prev = flags();
    btn_start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (flags() !== prev) begin
        changes++;
        if (first < 0) first = i;
        prev = flags();
      end
      if (i == 10) btn_start = 1'b0;
    end
    checks++;
    if (first - 1 !== 7) begin
      errors++;
      $display("FAIL start_latency got %0d want 7", first - 1);
    end
    checks++;
    if (changes !== 1 || flags() !== F_RUN) begin
      errors++;
      $display("FAIL start_once got %0d changes flags %b want 1 %b",
               changes, flags(), F_RUN);
    end
    checks++;
    if (lives !== 3'd3 || score !== 8'd0) begin
      errors++;
      $display("FAIL start_vals got lives %0d score %0d want 3 0",
               lives, score);
    end
  endtask

  task automatic test_hits();
    enemy_collide = 4'b0001;
    @(negedge clk);
    checks++;
    if (lives !== 3'd2) begin
      errors++;
      $display("FAIL hit_first got %0d want 2", lives);
    end
    repeat (2) @(negedge clk);
    enemy_collide = 4'b0011;
    @(negedge clk);
    checks++;
    if (lives !== 3'd2) begin
      errors++;
      $display("FAIL hit_cooldown got %0d want 2", lives);
    end
    repeat (8) @(negedge clk);
    enemy_collide = 4'b0111;
    @(negedge clk);
    checks++;
    if (lives !== 3'd1) begin
      errors++;
      $display("FAIL hit_after_cd got %0d want 1", lives);
    end
    enemy_collide = 4'b0000;
    repeat (12) @(negedge clk);
    enemy_collide = 4'b1001;
    @(negedge clk);
    checks++;
    if (lives !== 3'd0 || flags() !== F_OVER) begin
      errors++;
      $display("FAIL hit_over got lives %0d flags %b want 0 %b",
               lives, flags(), F_OVER);
    end
  endtask

  task automatic test_win();
    press(1'b1);
    checks++;
    if (flags() !== F_MENU) begin
      errors++;
      $display("FAIL over_to_menu got %b want %b", flags(), F_MENU);
    end
    press(1'b1);
    checks++;
    if (flags() !== F_RUN || lives !== 3'd3 || score !== 8'd0) begin
      errors++;
      $display("FAIL rerun got %b l%0d s%0d want %b l3 s0",
               flags(), lives, score, F_RUN);
    end
    enemy_collide = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      food_collide = 1'b1;
      @(negedge clk);
      checks++;
      if (score !== 8'(k)
          || flags() !== ((k < WS) ? F_RUN : F_WIN)) begin
        errors++;
        $display("FAIL eat_%0d got s%0d %b want s%0d", k, score,
                 flags(), k);
      end
      food_collide = 1'b0;
      @(negedge clk);
    end
    press(1'b1);
    checks++;
    if (flags() !== F_MENU || score !== 8'd5) begin
      errors++;
      $display("FAIL win_menu got %b s%0d want %b s5",
               flags(), score, F_MENU);
    end
    press(1'b1);
    checks++;
    if (flags() !== F_RUN || score !== 8'd0 || lives !== 3'd3) begin
      errors++;
      $display("FAIL new_game got %b s%0d l%0d want %b s0 l3",
               flags(), score, lives, F_RUN);
    end
  endtask

  task automatic test_pause();
    press(1'b0);
    checks++;
    if (flags() !== F_PAUSE) begin
      errors++;
      $display("FAIL pause_enter got %b want %b", flags(), F_PAUSE);
    end
    food_collide = 1'b1;
    @(negedge clk);
    food_collide = 1'b0;
    enemy_collide = 4'b0010;
    @(negedge clk);
    enemy_collide = 4'b0000;
    @(negedge clk);
    checks++;
    if (flags() !== F_PAUSE || score !== 8'd0 || lives !== 3'd3) begin
      errors++;
      $display("FAIL pause_frozen got %b s%0d l%0d want %b s0 l3",
               flags(), score, lives, F_PAUSE);
    end
    food_collide = 1'b1;
    @(negedge clk);
    press(1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if (flags() !== F_RUN || score !== 8'd0) begin
      errors++;
      $display("FAIL resume got %b s%0d want %b s0",
               flags(), score, F_RUN);
    end
    food_collide = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 4; k++) begin
      food_collide = 1'b1;
      @(negedge clk);
      food_collide = 1'b0;
      @(negedge clk);
    end
    enemy_collide = 4'b0001;
    @(negedge clk);
    enemy_collide = 4'b0000;
    repeat (10) @(negedge clk);
    enemy_collide = 4'b0100;
    @(negedge clk);
    enemy_collide = 4'b0000;
    repeat (10) @(negedge clk);
    checks++;
    if (lives !== 3'd1 || score !== 8'd4 || flags() !== F_RUN) begin
      errors++;
      $display("FAIL simul_setup got l%0d s%0d %b want l1 s4 %b",
               lives, score, flags(), F_RUN);
    end
    enemy_collide = 4'b1000;
    food_collide = 1'b1;
    @(negedge clk);
    checks++;
    if (flags() !== F_OVER || score !== 8'd5 || lives !== 3'd0) begin
      errors++;
      $display("FAIL simul_over got %b s%0d l%0d want %b s5 l0",
               flags(), score, lives, F_OVER);
    end
    enemy_collide = 4'b0000;
    food_collide = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    press(1'b1);
    press(1'b1);
    food_collide = 1'b1;
    @(negedge clk);
    food_collide = 1'b0;
    @(negedge clk);
    checks++;
    if (flags() !== F_RUN || score !== 8'd1) begin
      errors++;
      $display("FAIL arst_setup got %b s%0d want %b s1",
               flags(), score, F_RUN);
    end
    btn_start = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (flags() !== F_MENU || score !== 8'd0 || lives !== 3'(LI)) begin
      errors++;
      $display("FAIL arst_async got %b s%0d l%0d want %b s0 l%0d",
               flags(), score, lives, F_MENU, LI);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    btn_start = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (flags() !== F_MENU) begin
      errors++;
      $display("FAIL arst_release got %b want %b", flags(), F_MENU);
    end
  endtask

  task automatic test_random();
    bit sp [NC + 16];
    bit pp [NC + 16];
    int m_state;
    int m_lives;
    int m_score;
    int m_cd;
    logic [3:0] m_en;
    logic m_fd;
    logic [4:0] exp_f;
    bit s_high;
    bit p_high;
    int s_left;
    int p_left;
    bit hit;
    int fails;
    for (int i = 0; i < NC + 16; i++) begin
      sp[i] = 1'b0;
      pp[i] = 1'b0;
    end
    btn_start = 1'b0;
    btn_pause = 1'b0;
    enemy_collide = 4'd0;
    food_collide = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_state = 0;
    m_lives = LI;
    m_score = 0;
    m_cd = 0;
    m_en = 4'd0;
    m_fd = 1'b0;
    s_high = 1'b0;
    p_high = 1'b0;
    s_left = 10;
    p_left = 10;
    fails = 0;
    for (int e = 0; e < NC; e++) begin
      @(negedge clk);
      exp_f = 5'b10000 >> m_state;
      checks++;
      if (flags() !== exp_f || score !== 8'(m_score)
          || lives !== 3'(m_lives)) begin
        errors++;
        fails++;
        $display("FAIL rand_c%0d got %b s%0d l%0d want %b s%0d l%0d",
                 e, flags(), score, lives, exp_f, m_score, m_lives);
      end
      if (fails > 20) break;
      if (s_left == 0) begin
        if (s_high) begin
          s_high = 1'b0;
          s_left = $urandom_range(20, 8);
        end else if ($urandom_range(7, 0) == 0) begin
          s_high = 1'b1;
          s_left = $urandom_range(10, 7);
          sp[e + DB + 3] = 1'b1;
        end
      end
      if (p_left == 0) begin
        if (p_high) begin
          p_high = 1'b0;
          p_left = $urandom_range(20, 8);
        end else if ($urandom_range(5, 0) == 0) begin
          p_high = 1'b1;
          p_left = $urandom_range(10, 7);
          pp[e + DB + 3] = 1'b1;
        end
      end
      if (s_left > 0) s_left--;
      if (p_left > 0) p_left--;
      btn_start = s_high;
      btn_pause = p_high;
      if ($urandom_range(5, 0) == 0) enemy_collide = 4'($urandom);
      if ($urandom_range(3, 0) == 0) food_collide = ~food_collide;
      // Game rules applied to what the next rising edge will sample.
      case (m_state)
        0: begin
          if (sp[e]) begin
            m_state = 1;
            m_lives = LI;
            m_score = 0;
            m_cd = 0;
          end
        end
        1: begin
          hit = (|(enemy_collide & ~m_en)) && (m_cd == 0);
          if (hit) begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_cd = HC;
          end else if (m_cd > 0) begin
            m_cd--;
          end
          if (food_collide && !m_fd && m_score < 255) m_score++;
          if (m_lives == 0) m_state = 3;
          else if (m_score >= WS) m_state = 4;
          else if (pp[e]) m_state = 2;
        end
        2: begin
          if (sp[e]) m_state = 0;
          else if (pp[e]) m_state = 1;
        end
        default: begin
          if (sp[e]) m_state = 0;
        end
      endcase
      m_en = enemy_collide;
      m_fd = food_collide;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hits();
    test_win();
    test_pause();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
